// File: rtl/shares_recombine.sv
// shares_recombine: serial unmasking of a d-share Boolean-masked word.
//
// Accepts one masked word (d shares of W bits) and XORs one share per cycle into an
// accumulator, so no single cycle ever combines all shares combinationally. Consumed
// share slots are zeroized as they are folded in, and the accumulator is cleared when
// the result leaves without a new word behind it.
//
// Ports:
//   clk        in   1    system clock, rising edge
//   rst        in   1    asynchronous, active-high reset
//   in_valid   in   1    masked word available on in_shares
//   in_ready   out  1    block accepts in_shares this cycle
//   in_shares  in   d*W  share i at bits [i*W +: W]
//   out_valid  out  1    out_data holds a recombined word
//   out_ready  in   1    sink accepts out_data this cycle
//   out_data   out  W    unmasked word, 0 whenever out_valid is low
module shares_recombine #(
    parameter int unsigned d = 2,
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [d*W-1:0] in_shares,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data
);

    localparam int unsigned CW = (d > 1) ? $clog2(d) : 1;

    typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

    state_e              state_q, state_d;
    logic [d-1:0][W-1:0] share_q, share_d;  // slot 0 is never stored; share 0 seeds acc
    logic [W-1:0]        acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                accept;

    // Kept as a distinct gate so synthesis cannot merge shares across the accumulator.
    (* keep = "true", dont_touch = "true", keep_hierarchy = "yes" *)
    logic [W-1:0]        acc_xor;

    assign acc_xor = acc_q ^ share_q[cnt_q];

    // Depends on state and out_ready only; in_valid never reaches an output.
    assign in_ready  = !rst && ((state_q == StIdle) || ((state_q == StOut) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StOut);
    assign out_data  = out_valid ? acc_q : '0;

    always_comb begin
        state_d = state_q;
        share_d = share_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
            end
            StAcc: begin
                acc_d          = acc_xor;
                share_d[cnt_q] = '0;
                if (cnt_q == CW'(d - 1)) begin
                    // Last share folded in; park cnt at 0 instead of wrapping.
                    state_d = StOut;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StOut: begin
                if (out_ready && !in_valid) begin
                    acc_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // New word from IDLE or overlapping the OUT handshake.
        if (accept) begin
            share_d[0] = '0;
            for (int unsigned i = 1; i < d; i++) begin
                share_d[i] = in_shares[i*W +: W];
            end
            acc_d   = in_shares[W-1:0];
            cnt_d   = (d > 1) ? CW'(1) : '0;
            state_d = (d > 1) ? StAcc : StOut;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            share_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            share_q <= share_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_shares_recombine.sv
// Bench for shares_recombine: four instances with d = 1, 2, 3, 4 (W = 8) share one
// clock and reset. A negedge monitor pushes the XOR of the shares on every input
// transfer and pops/compares on every output transfer; the initial block runs the
// directed cases and then a random-stall run on the d = 2..4 instances.
module tb_shares_recombine;

    logic        clk;
    logic        rst;
    logic        in_valid  [4];
    logic        in_ready  [4];
    logic [31:0] in_shares [4];
    logic        out_valid [4];
    logic        out_ready [4];
    logic [7:0]  out_data  [4];

    int checks;
    int errors;

    logic [7:0] exp_q [4][$];
    int         outs  [4];
    logic       stall [4];
    logic [7:0] held  [4];

    for (genvar k = 0; k < 4; k++) begin : g_dut
        shares_recombine #(
            .d(k + 1),
            .W(8)
        ) u (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[k]),
            .in_ready (in_ready[k]),
            .in_shares(in_shares[k][(k+1)*8-1:0]),
            .out_valid(out_valid[k]),
            .out_ready(out_ready[k]),
            .out_data (out_data[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
        end
    endtask

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [7:0] x;
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                stall[k] = 1'b0;
            end else begin
                if (stall[k]) begin
                    check($sformatf("hold_valid_%0d", k), out_valid[k], 1);
                    check($sformatf("hold_data_%0d", k), out_data[k], held[k]);
                end
                if (!out_valid[k]) check($sformatf("idle_zero_%0d", k), out_data[k], 0);
                if (in_valid[k] && in_ready[k]) begin
                    x = '0;
                    for (int j = 0; j <= k; j++) x ^= in_shares[k][j*8 +: 8];
                    exp_q[k].push_back(x);
                end
                if (out_valid[k] && out_ready[k]) begin
                    outs[k]++;
                    check($sformatf("sb_nonempty_%0d", k), exp_q[k].size() != 0, 1);
                    if (exp_q[k].size() != 0)
                        check($sformatf("sb_data_%0d", k), out_data[k], exp_q[k].pop_front());
                end
                stall[k] = out_valid[k] && !out_ready[k];
                held[k]  = out_data[k];
            end
        end
    end

    task automatic send(input int k, input logic [31:0] shares);
        logic got;
        got          = 1'b0;
        in_valid[k]  = 1'b1;
        in_shares[k] = shares;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = in_ready[k];
        end
        check($sformatf("send_ready_%0d", k), got, 1);
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_out(input int k);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            got = out_valid[k];
        end
        check($sformatf("out_timeout_%0d", k), got, 1);
    endtask

    initial begin
        int   first, second, nacc, base;
        logic [7:0] o1, o2;
        logic acc_now [4];
        int   rem [4];
        logic done;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid[k]  = 1'b0;
            in_shares[k] = '0;
            out_ready[k] = 1'b0;
            outs[k]      = 0;
            stall[k]     = 1'b0;
        end

        // Reset state
        #3;
        for (int k = 0; k < 4; k++) begin
            check("rst_in_ready", in_ready[k], 0);
            check("rst_out_valid", out_valid[k], 0);
            check("rst_out_data", out_data[k], 0);
        end
        #9;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) check("idle_in_ready", in_ready[k], 1);
        check("rst_acc", g_dut[2].u.acc_q, 0);
        check("rst_share", g_dut[2].u.share_q, 0);
        check("rst_cnt", g_dut[2].u.cnt_q, 0);
        @(posedge clk);
        #1;

        // 1. d=2: 0xA5 ^ 0x0F = 0xAA, in_ready high while the result is taken
        out_ready[1] = 1'b1;
        send(1, 32'h0000_0FA5);
        wait_out(1);
        check("t1_data", out_data[1], 8'hAA);
        check("t1_in_ready", in_ready[1], 1);
        check("t1_share_zero", g_dut[1].u.share_q, 0);
        @(negedge clk);
        check("t1_drained", out_valid[1], 0);
        check("t1_acc_clear", g_dut[1].u.acc_q, 0);
        @(posedge clk);
        #1;

        // 2. d=3: 0x11^0x22^0x44 = 0x77 held under back-pressure, single transfer
        out_ready[2] = 1'b0;
        send(2, 32'h0044_2211);
        wait_out(2);
        check("t2_share_zero", g_dut[2].u.share_q, 0);
        base = outs[2];
        for (int i = 0; i < 5; i++) begin
            check("t2_valid", out_valid[2], 1);
            check("t2_data", out_data[2], 8'h77);
            check("t2_in_ready", in_ready[2], 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready[2] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[2] = 1'b0;
        @(negedge clk);
        check("t2_one_transfer", outs[2] - base, 1);
        check("t2_drained", out_valid[2], 0);
        @(posedge clk);
        #1;

        // 3. d=2 back-to-back: 0x03 then 0xFF, two cycles apart
        out_ready[1] = 1'b1;
        in_valid[1]  = 1'b1;
        in_shares[1] = 32'h0000_0201;
        first  = -1;
        second = -1;
        nacc   = 0;
        o1     = '0;
        o2     = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            acc_now[1] = in_valid[1] && in_ready[1];
            if (out_valid[1]) begin
                if (first < 0) begin
                    first = i;
                    o1    = out_data[1];
                end else if (second < 0) begin
                    second = i;
                    o2     = out_data[1];
                end
            end
            @(posedge clk);
            #1;
            if (acc_now[1]) begin
                nacc++;
                if (nacc == 1) in_shares[1] = 32'h0000_0FF0;
                else in_valid[1] = 1'b0;
            end
        end
        check("t3_first", o1, 8'h03);
        check("t3_second", o2, 8'hFF);
        check("t3_spacing", second - first, 2);

        // 4. d=3: reset during ACC drops the word, then a clean restart
        out_ready[2] = 1'b1;
        send(2, 32'h0033_2211);
        check("t4_cnt_before", g_dut[2].u.cnt_q, 1);
        rst = 1'b1;
        #1;
        check("t4_out_valid", out_valid[2], 0);
        check("t4_share", g_dut[2].u.share_q, 0);
        check("t4_acc", g_dut[2].u.acc_q, 0);
        check("t4_cnt", g_dut[2].u.cnt_q, 0);
        check("t4_in_ready", in_ready[2], 0);
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_no_emit", out_valid[2], 0);
        end
        @(posedge clk);
        #1;
        send(2, 32'h0001_0080);
        wait_out(2);
        check("t4_data", out_data[2], 8'h81);
        @(posedge clk);
        #1;

        // 5. d=1: result one edge after accept; stalled in_valid changes nothing
        out_ready[0] = 1'b0;
        send(0, 32'h0000_005C);
        @(negedge clk);
        check("t5_valid", out_valid[0], 1);
        check("t5_data", out_data[0], 8'h5C);
        @(posedge clk);
        #1;
        in_valid[0]  = 1'b1;
        in_shares[0] = 32'h0000_00FF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_held", out_data[0], 8'h5C);
            check("t5_in_ready", in_ready[0], 0);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        @(negedge clk);
        check("t5_next", out_data[0], 8'hFF);
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;

        // 6. random stalls on d = 2, 3, 4
        rem[0] = 0;
        rem[1] = 334;
        rem[2] = 333;
        rem[3] = 333;
        for (int k = 1; k < 4; k++) acc_now[k] = 1'b0;
        base = outs[1] + outs[2] + outs[3];
        done = 1'b0;
        for (int c = 0; c < 30000 && !done; c++) begin
            @(negedge clk);
            for (int k = 1; k < 4; k++) acc_now[k] = in_valid[k] && in_ready[k];
            @(posedge clk);
            #1;
            done = 1'b1;
            for (int k = 1; k < 4; k++) begin
                if (acc_now[k]) rem[k]--;
                if (acc_now[k] || !in_valid[k]) begin
                    if (rem[k] > 0 && $urandom_range(0, 3) != 0) begin
                        in_valid[k]  = 1'b1;
                        in_shares[k] = $urandom;
                    end else begin
                        in_valid[k] = 1'b0;
                    end
                end
                out_ready[k] = ($urandom_range(0, 2) != 0);
                if (rem[k] > 0 || exp_q[k].size() != 0 || out_valid[k]) done = 1'b0;
            end
        end
        for (int k = 1; k < 4; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
        end
        check("t6_done", done, 1);
        check("t6_count", outs[1] + outs[2] + outs[3] - base, 1000);
        for (int k = 0; k < 4; k++) check("final_sb_empty", exp_q[k].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
